// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Bundles the signals between the five-stage pipeline datapath and its
// hazard / flush controller.
//
// Pipeline -> controller (hazard sources):
//   Rs_ID, Rt_ID, Uses_Rt_ID   register usage of the instruction in ID
//   MemRead_Ex, Rd_dst_Ex      load in Ex and its destination register
//   Branch_taken               branch resolved taken in Ex
//   Jump_ID                    jump decoded in ID
//   MD_start_Ex                mult/div in Ex issues to the MD unit
//   MFHL_ID                    ID instruction reads HI/LO
// Controller -> pipeline (control):
//   Keep_PC, Keep_IF_ID        hold the front end
//   Reset_IF_ID, Reset_ID_Ex   insert bubbles
//   MD_busy, MD_done           MD unit status
//   Stall_cnt, Flush_cnt       saturating performance counters
//
// Modports: master = pipeline datapath, slave = pipe_ctrl.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic [4:0]       Rs_ID;
  logic [4:0]       Rt_ID;
  logic             Uses_Rt_ID;
  logic             MemRead_Ex;
  logic [4:0]       Rd_dst_Ex;
  logic             Branch_taken;
  logic             Jump_ID;
  logic             MD_start_Ex;
  logic             MFHL_ID;

  logic             Keep_PC;
  logic             Keep_IF_ID;
  logic             Reset_IF_ID;
  logic             Reset_ID_Ex;
  logic             MD_busy;
  logic             MD_done;
  logic [CNT_W-1:0] Stall_cnt;
  logic [CNT_W-1:0] Flush_cnt;

  modport master (
    output Rs_ID, Rt_ID, Uses_Rt_ID, MemRead_Ex, Rd_dst_Ex,
           Branch_taken, Jump_ID, MD_start_Ex, MFHL_ID,
    input  Keep_PC, Keep_IF_ID, Reset_IF_ID, Reset_ID_Ex,
           MD_busy, MD_done, Stall_cnt, Flush_cnt
  );

  modport slave (
    input  Rs_ID, Rt_ID, Uses_Rt_ID, MemRead_Ex, Rd_dst_Ex,
           Branch_taken, Jump_ID, MD_start_Ex, MFHL_ID,
    output Keep_PC, Keep_IF_ID, Reset_IF_ID, Reset_ID_Ex,
           MD_busy, MD_done, Stall_cnt, Flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Hazard and flush controller for a five-stage pipeline with a multi-cycle
// multiply/divide unit.
//
//   - Load-use hazard: a load in Ex whose (non-zero) destination is read by the
//     instruction in ID stalls the front end for one cycle.
//   - MD hazard: while the MD unit is busy, an ID instruction reading HI/LO or
//     a new mult/div in Ex is stalled.
//   - A taken branch flushes IF/ID and ID/Ex and overrides every stall.
//   - A jump in ID flushes IF/ID only, and only when nothing else is happening.
//   - A two-state FSM tracks MD occupancy (MD_CYCLES cycles) and pulses MD_done
//     for one cycle on completion.
//   - Stall and flush cycles are counted in saturating CNT_W-bit counters.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipe_ctrl_if.slave, see the interface file for the signal list
// Parameters:
//   MD_CYCLES  MD unit occupancy in cycles (2..255)
//   CNT_W      width of the performance counters, must match bus CNT_W
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE_RUN = 1'b0,
    MD_WAIT  = 1'b1
  } state_t;

  // The counter starts at MD_CYCLES-1 and the FSM leaves MD_WAIT on the cycle
  // it reads zero, giving exactly MD_CYCLES cycles of occupancy.
  localparam logic [7:0]       MD_LOAD = 8'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [7:0]       r_md_cnt;
  logic             r_md_done;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_md_busy;
  logic             w_lu;
  logic             w_mh;
  logic             w_stall;
  logic             w_jump_flush;
  logic             w_flush_evt;

  // ---------------------------------------------------------------------------
  // Hazard detection (combinational, same-cycle response)
  // ---------------------------------------------------------------------------
  assign w_md_busy = (r_state == MD_WAIT);

  // Register 0 is hard-wired to zero, so a load targeting it never creates a
  // real dependency.
  assign w_lu = bus.MemRead_Ex
              & (bus.Rd_dst_Ex != 5'd0)
              & ((bus.Rd_dst_Ex == bus.Rs_ID)
                 | (bus.Uses_Rt_ID & (bus.Rd_dst_Ex == bus.Rt_ID)));

  assign w_mh = w_md_busy & (bus.MFHL_ID | bus.MD_start_Ex);

  // A taken branch kills the instructions that would have been held, so the
  // stall is suppressed rather than merely out-prioritised.
  assign w_stall = (w_lu | w_mh) & ~bus.Branch_taken;

  // A stalled jump stays in ID and is flushed on the cycle it finally proceeds.
  assign w_jump_flush = bus.Jump_ID & ~w_stall & ~bus.Branch_taken;
  assign w_flush_evt  = bus.Branch_taken | w_jump_flush;

  assign bus.Keep_PC     = w_stall;
  assign bus.Keep_IF_ID  = w_stall;
  assign bus.Reset_IF_ID = bus.Branch_taken | w_jump_flush;
  assign bus.Reset_ID_Ex = bus.Branch_taken | w_stall;

  assign bus.MD_busy   = w_md_busy;
  assign bus.MD_done   = r_md_done;
  assign bus.Stall_cnt = r_stall_cnt;
  assign bus.Flush_cnt = r_flush_cnt;

  // ---------------------------------------------------------------------------
  // MD occupancy FSM
  // A branch in MD_WAIT does not abort the unit, and an MD_start_Ex seen in
  // MD_WAIT is a stalled instruction, not a restart.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignment so every flop samples the
  // pre-edge values; blocking here would make ordering within the block matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE_RUN;
      r_md_cnt  <= 8'd0;
      r_md_done <= 1'b0;
    end else begin
      r_md_done <= 1'b0;
      case (r_state)
        IDLE_RUN: begin
          if (bus.MD_start_Ex) begin
            r_state  <= MD_WAIT;
            r_md_cnt <= MD_LOAD;
          end
        end
        MD_WAIT: begin
          if (r_md_cnt == 8'd0) begin
            r_state   <= IDLE_RUN;
            r_md_done <= 1'b1;
          end else begin
            r_md_cnt <= r_md_cnt - 8'd1;
          end
        end
        default: begin
          r_state  <= IDLE_RUN;
          r_md_cnt <= 8'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MD_CYCLES, default 32, multiply/divide unit occupancy in cycles (legal range 2..255).
REQ-002 Parameter CNT_W, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 Rs_ID  input  5  rs field of the instruction in ID.
REQ-006 Rt_ID  input  5  rt field of the instruction in ID.
REQ-007 Uses_Rt_ID  input  1  ID instruction reads rt as a source.
REQ-008 MemRead_Ex  input  1  instruction in Ex is a load.
REQ-009 Rd_dst_Ex  input  5  destination register of the instruction in Ex.
REQ-010 Branch_taken  input  1  branch resolved taken in Ex this cycle.
REQ-011 Jump_ID  input  1  instruction in ID is a jump.
REQ-012 MD_start_Ex  input  1  mult/div instruction in Ex issues to the MD unit.
REQ-013 MFHL_ID  input  1  ID instruction reads HI/LO.
REQ-014 Keep_PC  output  1  hold PC.
REQ-015 Keep_IF_ID  output  1  hold the IF/ID register.
REQ-016 Reset_IF_ID  output  1  clear IF/ID to a bubble.
REQ-017 Reset_ID_Ex  output  1  clear ID/Ex to a bubble.
REQ-018 MD_busy  output  1  MD unit occupied (registered).
REQ-019 MD_done  output  1  one-cycle pulse at MD completion (registered).
REQ-020 Stall_cnt  output  CNT_W  stall cycles, saturating (registered).
REQ-021 Flush_cnt  output  CNT_W  flush events, saturating (registered).

Function
REQ-022 FSM states IDLE_RUN and MD_WAIT; MD_busy = (state == MD_WAIT).
REQ-023 Load-use hazard LU = MemRead_Ex & (Rd_dst_Ex != 0) & (Rd_dst_Ex == Rs_ID | (Uses_Rt_ID & Rd_dst_Ex == Rt_ID)).
REQ-024 MD hazard MH = MD_busy & (MFHL_ID | MD_start_Ex).
REQ-025 Stall S = (LU | MH) & ~Branch_taken; S drives Keep_PC=1, Keep_IF_ID=1, Reset_ID_Ex=1 combinationally in the same cycle.
REQ-026 Branch_taken drives Reset_IF_ID=1 and Reset_ID_Ex=1, Keep_PC=0, Keep_IF_ID=0; flush has priority over every stall.
REQ-027 Jump_ID with no stall and no Branch_taken drives Reset_IF_ID=1 only; Jump_ID under stall produces no flush that cycle.
REQ-028 IDLE_RUN -> MD_WAIT when MD_start_Ex=1; internal down-counter loads MD_CYCLES-1.
REQ-029 MD_WAIT: counter decrements each cycle; at counter==0 next state IDLE_RUN and MD_done=1 for exactly the following cycle.
REQ-030 MD_start_Ex during MD_WAIT does not restart the counter; it is stalled per REQ-024.
REQ-031 Branch_taken during MD_WAIT does not abort the MD operation; counter continues.
REQ-032 Stall_cnt increments by 1 each cycle S=1; Flush_cnt by 1 each cycle Branch_taken=1 or an REQ-027 flush occurs; both hold at 2^CNT_W-1.
REQ-033 All outputs defined (no X) whenever rst_n=1.

Reset
REQ-034 rst_n=0 immediately forces state IDLE_RUN, counter 0, MD_busy=0, MD_done=0, Stall_cnt=0, Flush_cnt=0, independent of clk.
REQ-035 Reset mid-MD_WAIT abandons the operation; no MD_done pulse after release.
REQ-036 Combinational outputs follow REQ-025..027 during reset with MD_busy=0.

Verification
REQ-037 MemRead_Ex=1, Rd_dst_Ex=5, Rs_ID=5 for 1 cycle -> Keep_PC=Keep_IF_ID=Reset_ID_Ex=1, Reset_IF_ID=0, Stall_cnt 0->1.
REQ-038 Same as REQ-037 but Rd_dst_Ex=0 -> no stall; Rt match with Uses_Rt_ID=0 -> no stall.
REQ-039 LU=1 and Branch_taken=1 same cycle -> Reset_IF_ID=Reset_ID_Ex=1, Keep_PC=0, Flush_cnt+1, Stall_cnt unchanged.
REQ-040 MD_start_Ex pulse with MD_CYCLES=32 -> MD_busy high 32 cycles, MD_done one cycle after MD_busy falls; MFHL_ID held high stalls exactly while MD_busy=1.
REQ-041 rst_n low at cycle 10 of MD_WAIT -> MD_busy=0 asynchronously, no MD_done afterwards, counters 0.
REQ-042 CNT_W=4, 20 consecutive stall cycles -> Stall_cnt saturates at 15.
